shared_reg_arbiter: RTL and testbench
=====================================

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter NREQ, default 8: number of write requesters sharing the register.
REQ-002 Parameter W, default 4: data width of the shared register.
REQ-003 Parameter MAXHOLD, default 4: maximum consecutive cycles one requester may hold the register under lock.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester write request, one bit per requester.
REQ-007 lock  input  NREQ  per-requester request to keep ownership; honoured only for the current owner.
REQ-008 d_in  input  NREQ*W  packed write data; requester i occupies bits [i*W+W-1 : i*W].
REQ-009 d_out  output  W  registered shared register contents.
REQ-010 ack  output  NREQ  registered one-hot write acknowledge; all-zero when no write occurred.
REQ-011 owner  output  clog2(NREQ)  index of the last requester that wrote.
REQ-012 busy  output  1  high while in state OWN.

Function
REQ-013 The block SHALL perform at most one write to d_out per cycle, so the shared register has a single driver.
REQ-014 State machine states SHALL be IDLE and OWN.
REQ-015 IDLE with req all-zero: stay IDLE; d_out, ptr and owner hold; ack = 0.
REQ-016 IDLE with any req bit set: the winner is the first set req bit at or after ptr, searching cyclically upward modulo NREQ.
REQ-017 On a win: d_out <= d_in slice of the winner; ack <= one-hot(winner); owner <= winner; ptr <= (winner+1) mod NREQ; hold_cnt <= 1; go to OWN.
REQ-018 OWN with req[owner] & lock[owner] & (hold_cnt < MAXHOLD): the owner writes again; ptr unchanged; hold_cnt increments.
REQ-019 OWN when the lock condition is false or hold_cnt = MAXHOLD: arbitrate as in REQ-016 from ptr.
REQ-020 In REQ-019, a hold_cnt = MAXHOLD forced rotation SHALL exclude the current owner from that arbitration.
REQ-021 In REQ-019, if the owner is the only requester and the rotation was not forced, the owner SHALL be re-granted and hold_cnt SHALL be set to 1.
REQ-022 OWN with no eligible requester: go to IDLE; ack = 0; d_out holds.
REQ-023 Write latency: the data and ack of a request sampled at edge N SHALL be visible after edge N; combinational request-to-output paths are forbidden.
REQ-024 ptr wrap-around: a winner of NREQ-1 SHALL set ptr to 0.
REQ-025 lock bits of non-owners SHALL be ignored.
REQ-026 A lock without req SHALL release ownership.
REQ-027 All req bits SHALL be treated symmetrically; fixed priority exists only through ptr.

Reset
REQ-028 While rst is high: state = IDLE, d_out = 0, ack = 0, owner = 0, ptr = 0, hold_cnt = 0, busy = 0, asynchronously and independent of clk.
REQ-029 Reset asserted mid-ownership SHALL abort the ownership with no write that cycle; after release, arbitration SHALL restart from ptr = 0.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, OWN) and the NREQ, W and MAXHOLD defaults.
REQ-031 A combinational sub-module rr_pick SHALL take (req mask, ptr) and return (found, index).
REQ-032 rr_pick SHALL be the only priority logic in the block.

Verification
REQ-033 Reset, then req=8'h00 for 5 cycles -> d_out=0, ack=0, busy=0, state IDLE.
REQ-034 req=8'hFF, lock=0, d_in slice i = i, for 9 cycles -> ack walks 01,02,..,80,01; d_out 0,1,..,7,0; ptr wraps after requester 7.
REQ-035 req=8'h24 (requesters 2 and 5), lock=0 -> grants alternate 2,5,2,5; d_out tracks d_in[2] or d_in[5].
REQ-036 req=8'h03, lock=8'h01, requester 0 first owner, MAXHOLD=4 -> owner 0 for 4 cycles, then forced grant to requester 1, then requester 0 again.
REQ-037 Requester 3 holding with lock, rst pulsed for 1 cycle mid-hold -> all outputs 0 during reset; the first grant after release follows a search from ptr=0.
REQ-038 Single requester 6 with lock removed after 2 cycles -> re-granted each cycle with hold_cnt=1 (REQ-021); after req drops, next cycle IDLE, ack=0, d_out holds the last value.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM states,
// default sizing and an index-width helper.
package shared_reg_arbiter_pkg;

  localparam int NREQ_DEF    = 8;
  localparam int W_DEF       = 4;
  localparam int MAXHOLD_DEF = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Index width that stays at least one bit for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin picker: first set bit of the request mask at or after ptr,
// searching cyclically upward. Purely combinational.
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int PW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            found_o,
  output logic [PW-1:0]   idx_o
);

  logic [PW-1:0] cand_s;

  // Scan from the farthest candidate down so the nearest hit to ptr wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = PW'((int'(ptr_i) + k) % NREQ);
      if (req_i[cand_s]) begin
        found_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shared register written by NREQ requesters under round-robin arbitration,
// with an optional bounded lock that lets the current owner keep writing.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int W       = W_DEF,
  parameter int MAXHOLD = MAXHOLD_DEF,
  localparam int PW     = idx_w(NREQ),
  localparam int HW     = $clog2(MAXHOLD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*W-1:0] d_in,
  output logic [W-1:0]      d_out,
  output logic [NREQ-1:0]   ack,
  output logic [PW-1:0]     owner,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [W-1:0]      d_out_q, d_out_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              busy_q;

  logic [W-1:0]      slice_s [NREQ];
  logic [NREQ-1:0]   owner_oh_s;
  logic [NREQ-1:0]   mask_s;
  logic              keep_s, forced_s;
  logic              found_s;
  logic [PW-1:0]     win_s;

  // Unpack the write data bus into per-requester slices.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slice_s[i] = d_in[i*W +: W];
    end
  end

  // Lock continuation and forced-rotation conditions; a forced rotation
  // removes the owner from the candidate mask.
  always_comb begin
    owner_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    keep_s     = (state_q == OWN) && req[owner_q] && lock[owner_q] &&
                 (hold_q < HW'(MAXHOLD));
    forced_s   = (state_q == OWN) && (hold_q >= HW'(MAXHOLD));
    mask_s     = forced_s ? (req & ~owner_oh_s) : req;
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (mask_s),
    .ptr_i   (ptr_q),
    .found_o (found_s),
    .idx_o   (win_s)
  );

  // Next-state: at most one write per cycle, either the locked owner or the arbitration winner.
  always_comb begin
    state_d = state_q;
    d_out_d = d_out_q;
    ack_d   = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (keep_s) begin
      d_out_d = slice_s[owner_q];
      ack_d   = owner_oh_s;
      hold_d  = hold_q + HW'(1);
      state_d = OWN;
    end else if (found_s) begin
      d_out_d = slice_s[win_s];
      ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
      owner_d = win_s;
      ptr_d   = (win_s == PW'(NREQ - 1)) ? '0 : (win_s + PW'(1));
      hold_d  = HW'(1);
      state_d = OWN;
    end else begin
      hold_d  = '0;
      state_d = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_out_q <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_out_q <= d_out_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= (state_d == OWN);
    end
  end

  assign d_out = d_out_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed vectors push the expected
// post-edge outputs; a monitor pops and compares one entry per clock.
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [7:0]  lock;
  logic [31:0] d_in;
  logic [3:0]  d_out;
  logic [7:0]  ack;
  logic [2:0]  owner;
  logic        busy;

  typedef struct {
    logic [7:0] ack;
    logic [3:0] dout;
    logic [2:0] own;
    logic       busy;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [31:0] D0 = 32'h7654_3210;
  localparam logic [31:0] D1 = 32'hFEDC_BA98;

  shared_reg_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .lock  (lock),
    .d_in  (d_in),
    .d_out (d_out),
    .ack   (ack),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    n_cmp++;
    if (ack !== e.ack || d_out !== e.dout || owner !== e.own || busy !== e.busy) begin
      n_err++;
      $display("FAIL %s: got ack=%h d_out=%h owner=%0d busy=%b, want ack=%h d_out=%h owner=%0d busy=%b",
               e.nm, ack, d_out, owner, busy, e.ack, e.dout, e.own, e.busy);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r_v, input logic [7:0] rq, input logic [7:0] lk,
                      input logic [31:0] din, input logic [7:0] eack, input logic [3:0] edo,
                      input logic [2:0] eown, input logic ebusy, input string nm);
    exp_t e;
    @(posedge clk);
    #2;
    rst  = r_v;
    req  = rq;
    lock = lk;
    d_in = din;
    e.ack = eack; e.dout = edo; e.own = eown; e.busy = ebusy; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e);
      end
    end
  end

  initial begin : stim
    exp_t z;
    z.ack = 8'h00; z.dout = 4'h0; z.own = 3'd0; z.busy = 1'b0;
    rst = 1'b1; req = 8'h00; lock = 8'h00; d_in = D0;
    repeat (2) @(posedge clk);
    #1;
    z.nm = "reset_state";
    check(z);

    for (int k = 0; k < 5; k++)
      step(1'b0, 8'h00, 8'h00, D0, 8'h00, 4'h0, 3'd0, 1'b0, "idle_no_req");

    for (int k = 0; k < 8; k++)
      step(1'b0, 8'hFF, 8'h00, D0, 8'h01 << k, 4'(k), 3'(k), 1'b1, "rr_walk");
    step(1'b0, 8'hFF, 8'h00, D0, 8'h01, 4'h0, 3'd0, 1'b1, "rr_wrap");
    step(1'b0, 8'h00, 8'h00, D0, 8'h00, 4'h0, 3'd0, 1'b0, "rr_release");

    for (int k = 0; k < 2; k++) begin
      step(1'b0, 8'h24, 8'h00, D1, 8'h04, 4'hA, 3'd2, 1'b1, "alt_2");
      step(1'b0, 8'h24, 8'h00, D1, 8'h20, 4'hD, 3'd5, 1'b1, "alt_5");
    end
    step(1'b0, 8'h00, 8'h00, D1, 8'h00, 4'hD, 3'd5, 1'b0, "alt_idle_hold");

    for (int k = 0; k < 4; k++)
      step(1'b0, 8'h03, 8'h01, D0, 8'h01, 4'h0, 3'd0, 1'b1, "lock_hold0");
    step(1'b0, 8'h03, 8'h01, D0, 8'h02, 4'h1, 3'd1, 1'b1, "forced_to1");
    step(1'b0, 8'h03, 8'h01, D0, 8'h01, 4'h0, 3'd0, 1'b1, "back_to0");
    step(1'b0, 8'h00, 8'h00, D0, 8'h00, 4'h0, 3'd0, 1'b0, "lock_release");

    step(1'b0, 8'h08, 8'h08, D0, 8'h08, 4'h3, 3'd3, 1'b1, "own3");
    step(1'b0, 8'h08, 8'h08, D0, 8'h08, 4'h3, 3'd3, 1'b1, "own3_hold");
    step(1'b1, 8'h08, 8'h08, D0, 8'h00, 4'h0, 3'd0, 1'b0, "rst_mid");
    #1;
    z.nm = "async_rst";
    check(z);
    step(1'b0, 8'h28, 8'h08, D0, 8'h08, 4'h3, 3'd3, 1'b1, "post_rst_ptr0");
    step(1'b0, 8'h28, 8'h08, D0, 8'h08, 4'h3, 3'd3, 1'b1, "post_rst_hold");
    step(1'b0, 8'h00, 8'h00, D0, 8'h00, 4'h3, 3'd3, 1'b0, "post_rst_idle");

    step(1'b0, 8'h40, 8'h40, D0, 8'h40, 4'h6, 3'd6, 1'b1, "solo6");
    step(1'b0, 8'h40, 8'h40, D0, 8'h40, 4'h6, 3'd6, 1'b1, "solo6_lock");
    step(1'b0, 8'h40, 8'h00, D0, 8'h40, 4'h6, 3'd6, 1'b1, "solo6_regrant");
    step(1'b0, 8'h40, 8'h00, D0, 8'h40, 4'h6, 3'd6, 1'b1, "solo6_regrant");
    for (int k = 0; k < 3; k++)
      step(1'b0, 8'h40, 8'h40, D0, 8'h40, 4'h6, 3'd6, 1'b1, "solo6_relock");
    step(1'b0, 8'h40, 8'h40, D0, 8'h00, 4'h6, 3'd6, 1'b0, "solo6_forced_idle");
    step(1'b0, 8'h40, 8'h40, D0, 8'h40, 4'h6, 3'd6, 1'b1, "solo6_again");
    step(1'b0, 8'h00, 8'h00, D0, 8'h00, 4'h6, 3'd6, 1'b0, "solo6_drop");
    step(1'b0, 8'h00, 8'h00, D0, 8'h00, 4'h6, 3'd6, 1'b0, "solo6_idle");

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
